// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: shared state encoding, divider code type and power-up divider codes for pll_dyn_ctrl.
package pll_ctrl_pkg;
    typedef enum logic [1:0] {HOLD, WAIT_LOCK, RUN, FAIL} state_t;
    typedef logic [5:0] sel_t;
    localparam sel_t DEF_IDSEL_CODE = 6'd59;
    localparam sel_t DEF_FBDSEL_CODE = 6'd57;
    localparam sel_t DEF_ODSEL_CODE = 6'd62;
endpackage

// File: rtl/lock_sync.sv
// lock_sync: two-flop synchroniser bringing the asynchronous rPLL LOCK into the board clock domain.
module lock_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic [1:0] ff;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ff <= '0;
        else ff <= {ff[0], d};
    end
    assign q = ff[1];
endmodule

// File: rtl/pll_dyn_ctrl.sv
// pll_dyn_ctrl: rPLL reset/lock sequencer with dynamic IDSEL/FBDSEL/ODSEL reconfiguration.
// Optional PLLCTL_LOSS_CNT_EN adds loss_cnt[7:0], a saturating count of lock-loss relocks.
module pll_dyn_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES = 16,
    parameter int STABLE_CYCLES = 1024,
    parameter int TIMEOUT = 65536,
    parameter int MAX_RETRY = 3,
    parameter logic [5:0] DEF_IDSEL = DEF_IDSEL_CODE,
    parameter logic [5:0] DEF_FBDSEL = DEF_FBDSEL_CODE,
    parameter logic [5:0] DEF_ODSEL = DEF_ODSEL_CODE
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [5:0] cfg_idsel,
    input  logic [5:0] cfg_fbdsel,
    input  logic [5:0] cfg_odsel,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       locked,
    output logic       out_rst_n,
`ifdef PLLCTL_LOSS_CNT_EN
    output logic [7:0] loss_cnt,
`endif
    output logic       fail
);
    localparam int CW = $clog2((TIMEOUT > RST_CYCLES ? TIMEOUT : RST_CYCLES) + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [SW-1:0] stable, stable_n;
    logic [3:0] retry, retry_n;
    sel_t idsel_n, fbdsel_n, odsel_n;
    logic lock_s, accept;
    lock_sync u_lock_sync (.clk(clk), .reset_n(reset_n), .d(pll_lock), .q(lock_s));
    assign accept = cfg_valid & cfg_ready;
    always_comb begin
        state_n = state;
        cnt_n = '0;
        stable_n = '0;
        retry_n = accept ? 4'd0 : retry;
        idsel_n = accept ? cfg_idsel : pll_idsel;
        fbdsel_n = accept ? cfg_fbdsel : pll_fbdsel;
        odsel_n = accept ? cfg_odsel : pll_odsel;
        case (state)
            HOLD: begin
                cnt_n = (cnt == RST_LAST) ? '0 : cnt + 1'b1;
                state_n = (cnt == RST_LAST) ? WAIT_LOCK : HOLD;
            end
            WAIT_LOCK: begin
                cnt_n = cnt + 1'b1;
                stable_n = lock_s ? stable + 1'b1 : '0;
                // a completed qualification beats a timeout landing on the same cycle
                if (lock_s && stable == STABLE_LAST) begin
                    state_n = RUN;
                    cnt_n = '0;
                    stable_n = '0;
                    retry_n = '0;
                end else if (cnt == TO_LAST) begin
                    cnt_n = '0;
                    stable_n = '0;
                    retry_n = retry + 4'd1;
                    state_n = (retry + 4'd1 == RETRY_MAX) ? FAIL : HOLD;
                end
            end
            RUN: state_n = (accept || !lock_s) ? HOLD : RUN;
            FAIL: state_n = accept ? HOLD : FAIL;
            default: state_n = HOLD;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= HOLD;
            cnt <= '0;
            stable <= '0;
            retry <= '0;
            pll_idsel <= DEF_IDSEL;
            pll_fbdsel <= DEF_FBDSEL;
            pll_odsel <= DEF_ODSEL;
            pll_reset <= 1'b1;
            locked <= 1'b0;
            out_rst_n <= 1'b0;
            fail <= 1'b0;
            cfg_ready <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            stable <= stable_n;
            retry <= retry_n;
            pll_idsel <= idsel_n;
            pll_fbdsel <= fbdsel_n;
            pll_odsel <= odsel_n;
            pll_reset <= (state_n == HOLD) || (state_n == FAIL);
            locked <= state_n == RUN;
            out_rst_n <= state_n == RUN;
            fail <= state_n == FAIL;
            cfg_ready <= (state_n == RUN) || (state_n == FAIL);
        end
    end
`ifdef PLLCTL_LOSS_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) loss_cnt <= '0;
        else if (state == RUN && !accept && !lock_s && loss_cnt != 8'hff) loss_cnt <= loss_cnt + 8'd1;
    end
`endif
endmodule
